// File: rtl/muldiv_pkg.sv
// Shared HI/LO unit definitions: R-type funct codes, FSM states and op kinds.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_kind_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the multiply/divide engine.
// Multiply: acc = {partial product, remaining multiplier}; add on multiplier LSB, shift right.
// Divide:   acc = {remainder, remaining dividend/quotient}; shift left, trial subtract, restore.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  op_kind_e           op_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  // Shift-add or restoring-subtract step selected by op kind
  always_comb begin
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : '0)};
    rem_sh   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_i});
    // When the trial subtract succeeds the result is below the divisor, so WIDTH bits suffice
    rem_diff = rem_sh[WIDTH-1:0] - opnd_i;
    if (op_i == OP_MUL) begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], rem_ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned DW    = 2 * WIDTH;

  state_e           state_q, state_d;
  op_kind_e         op_q, op_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [DW-1:0]    step_acc;
  logic             req_signed, req_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .op_i   (op_q),
    .acc_o  (step_acc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_MUL;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, operand capture, iteration and sign fixup
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    req_signed = (funct == FN_MULT) || (funct == FN_DIV);
    req_div    = (funct == FN_DIV)  || (funct == FN_DIVU);
    a_neg      = req_signed & rs_val[WIDTH-1];
    b_neg      = req_signed & rt_val[WIDTH-1];
    a_abs      = a_neg ? (~rs_val + WIDTH'(1)) : rs_val;
    b_abs      = b_neg ? (~rt_val + WIDTH'(1)) : rt_val;

    prod_fix = neg_res_q ? (~acc_q + DW'(1)) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[DW-1:WIDTH] + WIDTH'(1)) : acc_q[DW-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (start) begin
          case (funct)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              state_d = CALC;
              cnt_d   = CNT_W'(WIDTH - 1);
              if (req_div) begin
                op_d      = OP_DIV;
                acc_d     = {{WIDTH{1'b0}}, a_abs};
                opnd_d    = b_abs;
                // A zero divisor must leave the all-ones quotient unnegated
                neg_res_d = (a_neg ^ b_neg) && (rt_val != '0);
                neg_rem_d = a_neg;
              end else begin
                op_d      = OP_MUL;
                acc_d     = {{WIDTH{1'b0}}, b_abs};
                opnd_d    = a_abs;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = 1'b0;
              end
            end
            FN_MTHI: hi_d = rs_val;
            FN_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIXUP;
      end
      FIXUP: begin
        if (op_q == OP_MUL) begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct  (funct),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble operands to prove they were latched
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct  = f;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    rs_val = 32'hDEAD_BEEF;
    rt_val = 32'h0BAD_F00D;
  endtask

  // Count edges from acceptance until done shows up (bounded)
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n <= 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(f, a, b);
    check_eq({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(0, n);
    check_eq({tag, " latency"}, 32'(n), 32'd33);
    check_eq({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check_eq({tag, " hi"}, hi, exp_hi);
    check_eq({tag, " lo"}, lo, exp_lo);
    tick();
    check_eq({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int done_seen;
    n_checks = 0;
    n_errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    funct  = 6'd0;
    rs_val = '0;
    rt_val = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst hi", hi, 32'd0);
    check_eq("rst lo", lo, 32'd0);

    run_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  FN_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("divu_7_2",  FN_DIVU,  32'd7,         32'd2,         32'd1,         32'd3);
    run_op("div_m7_2",  FN_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",  FN_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op("div_ovf",   FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("divu_by0",  FN_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_by0",   FN_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Unknown funct in IDLE is ignored
    issue(6'b100000, 32'h1111_1111, 32'h2222_2222);
    check_eq("bad_funct busy", 32'(busy), 32'd0);
    check_eq("bad_funct hi", hi, 32'hFFFF_FFF9);

    // mthi in IDLE writes immediately, no busy, no done
    issue(FN_MTHI, 32'h0000_AAAA, 32'd0);
    check_eq("mthi hi", hi, 32'h0000_AAAA);
    check_eq("mthi lo_kept", lo, 32'hFFFF_FFFF);
    check_eq("mthi busy", 32'(busy), 32'd0);
    check_eq("mthi done", 32'(done), 32'd0);

    // Requests while busy are dropped; HI/LO hold until fixup completes
    issue(FN_MULT, 32'd2, 32'd3);
    check_eq("ign hi_stable", hi, 32'h0000_AAAA);
    start  = 1'b1;
    funct  = FN_MTLO;
    rs_val = 32'h55;
    tick();
    check_eq("ign mtlo_dropped", lo, 32'hFFFF_FFFF);
    funct  = FN_MULT;
    rs_val = 32'd7;
    rt_val = 32'd7;
    tick();
    start = 1'b0;
    check_eq("ign hi_hold", hi, 32'h0000_AAAA);
    wait_done(2, n);
    check_eq("ign latency", 32'(n), 32'd33);
    check_eq("ign hi", hi, 32'd0);
    check_eq("ign lo", lo, 32'd6);
    tick();
    check_eq("ign no_second_op", 32'(busy), 32'd0);

    // Reset in the middle of CALC aborts with no write and no done
    issue(FN_MULTU, 32'd9, 32'd9);
    for (int i = 0; i < 10; i++) tick();
    check_eq("abort busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort hi", hi, 32'd0);
    check_eq("abort lo", lo, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    check_eq("abort no_done", 32'(done_seen), 32'd0);
    check_eq("abort lo_final", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair used by the mult/multu/mfhi/mflo path.
- Accepts one R-type HI/LO operation at a time: mult, multu, div, divu, mthi, mtlo.
- Multiply uses an iterative shift-add engine; divide uses restoring division. Both run over WIDTH cycles.
- Raises busy so the pipeline controller can stall mfhi/mflo and further HI/LO operations until done.

Parameters:
- WIDTH, 32, operand and HI/LO width; CALC phase lasts exactly WIDTH cycles.

Ports:
- clk      in   1      single clock; all state updates on rising edge
- reset    in   1      synchronous, active-high
- start    in   1      request valid, sampled on the rising edge
- funct    in   6      R-type funct field of the request
- rs_val   in   WIDTH  operand A (dividend or multiplicand); value for mthi/mtlo
- rt_val   in   WIDTH  operand B (divisor or multiplier)
- busy     out  1      high while state is not IDLE
- done     out  1      one-cycle pulse when mult/multu/div/divu results land in hi/lo
- hi       out  WIDTH  HI register
- lo       out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulators cleared.
  - Reset overrides everything, including mid-CALC/FIXUP; the aborted operation produces no done and no HI/LO write.
- States: IDLE, CALC, FIXUP.
- IDLE, start=1:
  - funct 011000 (mult) or 011001 (multu) -> CALC.
  - funct 011010 (div) or 011011 (divu) -> CALC.
  - Signed ops latch |rs_val|, |rt_val| and the result-sign flags; unsigned ops latch raw operands. Iteration counter is loaded with WIDTH-1.
  - funct 010001 (mthi): hi<=rs_val at the same edge; stay IDLE; no busy; no done.
  - funct 010011 (mtlo): lo<=rs_val at the same edge; stay IDLE; no busy; no done.
  - Any other funct: ignored; no state change.
- CALC: one iteration per cycle.
  - Multiply: 2*WIDTH product accumulator, shift-add on the multiplier LSB.
  - Divide: restoring step; shift the remainder left, subtract the divisor, restore if negative, shift the quotient bit in.
  - Counter decrements each cycle; at 0 -> FIXUP.
- FIXUP (1 cycle):
  - Signed multiply: negate the full 2*WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Next edge: hi<=upper/remainder, lo<=lower/quotient, state->IDLE, done=1 for exactly that one cycle.
- Latency:
  - Start accepted at edge E0; busy=1 from E0 through E(WIDTH+1).
  - Results visible and done=1 in the cycle following E(WIDTH+1), i.e. 33 cycles after acceptance for WIDTH=32.
  - A new start is accepted in that done cycle.
- start while busy: ignored entirely, including mthi/mtlo. hi/lo remain stable and hold the prior values until FIXUP completes.
- Divide by zero (div or divu): lo=all ones, hi=rs_val; full latency; done asserted.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are consumed only at acceptance; rs_val/rt_val changes during CALC have no effect.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct constants FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU. These are shared with the existing ALU controller.
  - State enum {IDLE, CALC, FIXUP}.
  - An op-kind enum {OP_MUL, OP_DIV}.
- One combinational sub-module, muldiv_iter_step, computes a single shift-add or restoring-subtract iteration from the accumulator, operand and op-kind. The sequencer owns all registers and the FSM.

Test Plan:
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- mult rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then divu 7/2 -> lo=3, hi=1.
- div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234, done after 33 cycles.
- mthi 0xAAAA in IDLE -> hi=0xAAAA next cycle, busy=0, done=0. Then start mult 2*3 and issue mtlo 0x55 plus another mult while busy -> both ignored; final hi=0, lo=6.
- Start multu 9*9, assert reset at CALC cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse within the following 40 cycles.
